ex_muldiv_unit: RTL
===================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands, funct3 and destination register that the ID/EX pipeline register delivers for M-extension instructions. While it computes, it stalls the front of the pipeline, then presents a 32-bit result for one cycle so the EX/MEM register can capture it. It uses one shared radix-2 datapath: shift-add for multiply, restoring shift-subtract for divide.

## Interface
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start_i  in  1  a valid M-extension instruction is in EX; sampled only in IDLE
- flush_i  in  1  kill the in-flight operation (branch/jump redirect)
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data_i  in  XLEN  operand A (already forwarded)
- rs2_data_i  in  XLEN  operand B (already forwarded)
- rd_i  in  5  destination register
- stall_o  out  1  hold IF/ID/EX; combinational
- done_o  out  1  result_o and rd_o are valid this cycle
- result_o  out  XLEN  registered result
- rd_o  out  5  registered destination

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE + start_i:**
  - Latch funct3 and rd.
  - Latch operand magnitudes. Signed operands are rs1 for MULH/MULHSU/DIV/REM and rs2 for MULH/DIV/REM. Record negate flags.
  - Clear the 64-bit accumulator and the counter. Go to CALC.
- **Special cases, decided in IDLE:** go to DONE directly, with no CALC.
  - Divide by zero (rs2 == 0). DIV/DIVU give 0xFFFFFFFF. REM/REMU give rs1.
  - Signed overflow: DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF. DIV gives 0x80000000. REM gives 0.
- **CALC:** one bit per cycle for XLEN cycles. The counter runs 0..XLEN-1. Go to FIX when counter == XLEN-1.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half, then shift right by 1.
  - Divide: shift {remainder, quotient} left by 1. Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
- **FIX: apply signs.**
  - Product: negate the 64-bit product if the sign flags differ.
  - Quotient: negate if the sign flags differ.
  - Remainder: takes the sign of rs1.
  - Select output: MUL gives the low word. MULH/MULHSU/MULHU give the high word. DIV/DIVU give the quotient. REM/REMU give the remainder.
  - Register result_o and rd_o. Go to DONE.
- **DONE:** done_o = 1 for exactly one cycle, then go to IDLE. result_o and rd_o hold until the next completion.
- **stall_o** = (IDLE & start_i & ~flush_i) | CALC | FIX. It is 0 in DONE, so the pipeline advances and captures the result on that edge.
- **flush_i** in CALC or FIX: go to IDLE next edge. No done_o pulse; result_o and rd_o unchanged.
  - flush_i in DONE: has no effect; the result still completes.
  - flush_i in IDLE: start_i is ignored that cycle.
- start_i outside IDLE is ignored.
- Reset, at any time: state IDLE, counter 0, done_o 0, result_o 0, rd_o 0, accumulator 0. stall_o is 0 while start_i is low.
- Arithmetic:
  - All internal math is unsigned on magnitudes, on a 64-bit accumulator and a 33-bit trial subtract.
  - Magnitude of 0x80000000 is 0x80000000 as unsigned.
  - Results wrap modulo 2^XLEN.

## Timing
- Normal op, with start sampled at edge E0:
  - CALC spans edges E1..E32.
  - FIX is sampled at E33.
  - done_o is high in the cycle after E33, so latency is 34 edges.
  - stall_o is high from the start cycle through the FIX cycle, i.e. 34 cycles.
- Special case: done_o is high in the cycle after E0. stall_o is high only in the start cycle.
- Back-to-back: a new start_i is accepted in the cycle after DONE (IDLE). The earliest next start is 35 edges after the previous one.
- No combinational path from start_i to done_o or result_o.

## Test plan
- **MUL:** rs1 = 7, rs2 = 0xFFFFFFFD -> result 0xFFFFFFEB. done_o on the 34th cycle after start. stall_o high for exactly 34 cycles.
- **High-word multiplies:**
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- **Signed divide:**
  - DIV -7 / 2 -> 0xFFFFFFFD.
  - REM -7 / 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
  - rd_o equals the latched rd_i for each.
- **Corner cases:**
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - All three: done_o one cycle after start, no CALC stall.
- **Flush:**
  - flush_i at cycle 10 of a DIV -> no done_o, stall_o low next cycle, result_o unchanged.
  - An immediately following MUL 3 × 5 -> 15 with normal latency.
- **Reset and ignored start:**
  - reset asserted mid-CALC -> all outputs 0 next edge.
  - start_i toggled during CALC is ignored; exactly one done_o per accepted start.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// One radix-2 datapath is shared between multiply (shift-add) and divide
// (restoring shift-subtract). Operands are reduced to magnitudes on entry and
// signs are re-applied in the FIX state.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start_i                 valid M-instruction in EX (sampled in IDLE only)
//   flush_i                 kill in-flight operation
//   funct3_i                M-extension operation select
//   rs1_data_i, rs2_data_i  forwarded operands
//   rd_i                    destination register
//   stall_o                 hold IF/ID/EX (combinational)
//   done_o                  result_o / rd_o valid this cycle
//   result_o, rd_o          registered result and destination
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              done_q, done_d;

    // Operand decode: which operands are signed for this funct3
    logic              signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              is_div_i, div_by_zero, div_ovf;

    assign signed_a = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign signed_b = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                      (funct3_i == 3'b110);
    assign a_neg    = signed_a & rs1_data_i[XLEN-1];
    assign b_neg    = signed_b & rs2_data_i[XLEN-1];
    assign a_mag    = a_neg ? (~rs1_data_i + XLEN'(1)) : rs1_data_i;
    assign b_mag    = b_neg ? (~rs2_data_i + XLEN'(1)) : rs2_data_i;

    assign is_div_i    = funct3_i[2];
    assign div_by_zero = is_div_i && (rs2_data_i == '0);
    assign div_ovf     = is_div_i && !funct3_i[0] &&
                         (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (rs2_data_i == '1);

    // Multiply step: conditional add into upper half, then shift right
    logic [XLEN:0]     mul_sum;
    assign mul_sum = {1'b0, acc_q[AW-1:XLEN]} + ({1'b0, b_q} & {(XLEN+1){a_q[0]}});

    // Divide step: remainder lives in the upper half, quotient bits enter the
    // lower half; the dividend is fed MSB-first from a_q
    logic [XLEN:0]     rem_sh, trial;
    logic              trial_ok;
    assign rem_sh   = {acc_q[AW-1:XLEN], a_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, b_q};
    // A set top bit means rem_sh already exceeds any 32-bit divisor
    assign trial_ok = rem_sh[XLEN] | ~trial[XLEN];

    // Sign fix-up and result select
    logic [AW-1:0]     prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_result;
    assign prod_s = neg_res_q ? (~acc_q + AW'(1)) : acc_q;
    assign quot_s = neg_res_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    assign rem_s  = neg_rem_q ? (~acc_q[AW-1:XLEN] + XLEN'(1)) : acc_q[AW-1:XLEN];

    always_comb begin
        fix_result = prod_s[XLEN-1:0];
        case (op_q)
            3'b000:                 fix_result = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_s[AW-1:XLEN];
            3'b100, 3'b101:         fix_result = quot_s;
            default:                fix_result = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    op_d      = funct3_i;
                    rd_d      = rd_i;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    acc_d     = '0;
                    cnt_d     = '0;
                    if (div_by_zero) begin
                        result_d = funct3_i[1] ? rs1_data_i : '1;
                        rd_out_d = rd_i;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        rd_out_d = rd_i;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2]) begin
                        acc_d = {(trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0]),
                                 acc_q[XLEN-2:0], trial_ok};
                        a_d   = {a_q[XLEN-2:0], 1'b0};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                        a_d   = {1'b0, a_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = fix_result;
                    rd_out_d = rd_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_o  = ((state_q == IDLE) && start_i && !flush_i) ||
                      (state_q == CALC) || (state_q == FIX);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign rd_o     = rd_out_q;

endmodule
